signal_measure_multi: RTL and testbench
=======================================

Name: signal_measure_multi

Overview:
Multi-channel, parametrised successor to signal_measure_ctrl. One measurement engine is multiplexed over N_CH asynchronous inputs. Per run it accumulates period and high time over a runtime-selectable 2^k reference periods, with a selectable reference edge. It derives the average period and a per-mille duty cycle through an iterative divider, and reports a timeout on dead or stuck inputs. It sits between the pin-side signal inputs and the CSR/bus layer of the measurement subsystem.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz; used only for the TIMEOUT_CYC default.
N_CH, 4, number of input channels (≥1).
CNT_W, 26, width of the period and high-time accumulators.
MAX_AVG_LOG2, 4, maximum k; at most 2^k periods are accumulated.
TIMEOUT_CYC, CLK_FREQ, cycle budget from start to done. Must be < 2^CNT_W; this is checked by an elaboration-time assertion.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle request; accepted only in IDLE.
ch_sel  in  $clog2(N_CH) (min 1)  channel to measure; latched at start.
avg_log2  in  3  k; values above MAX_AVG_LOG2 are clamped; latched at start.
edge_pol  in  1  reference edge: 0 = rising, 1 = falling; latched at start.
sig_in  in  N_CH  asynchronous input signals.
busy  out  1  high from the cycle after start is accepted until the done cycle.
done  out  1  one-cycle completion pulse.
timeout  out  1  set with done when the run aborted; cleared on the next accepted start.
period_sum  out  CNT_W  clocks spanned by the 2^k periods.
high_sum  out  CNT_W  clocks within that window where the synced input was high.
period_avg  out  CNT_W  period_sum >> k.
duty_pm  out  10  floor(high_sum*1000/period_sum), clamped to 1000.

Behaviour:
- Reset state: all outputs 0 and the FSM in IDLE. Reset is asynchronous and applies at any point, including mid-run; no partial results survive.
- Input path: each channel passes through a 2-FF synchroniser, then a delay register for edge detection. An edge is visible 3 clk after a synchronous input change. Non-selected channels are ignored.
- IDLE: when start=1, latch ch_sel, clamped k and edge_pol; clear timeout, the accumulators and the timeout counter; go to ARM. Result outputs hold their previous values until the next done.
- ARM: wait for the first reference edge on the selected channel. The detection cycle is counted as cycle 1 of the window. Go to MEAS.
- MEAS: each cycle increments the period accumulator, and increments the high accumulator when the synced level is 1. The reference-edge counter advances on each edge. The cycle that detects the 2^k-th edge after arming is NOT counted; in that cycle the FSM goes to DIV. Result: period_sum equals the exact clock count between the arming edge and the final edge.
- DIV: restoring divider, numerator high_sum*1000 (CNT_W+10 bits), one quotient bit per clk. This takes exactly CNT_W+10 cycles. The quotient is clamped to 1000. period_sum ≥ 2 by construction, so no divide-by-zero path exists.
- DONE: a single cycle. done=1 and busy=0; period_sum, high_sum, period_avg and duty_pm update in this cycle. Next state is IDLE. A start arriving in DONE is ignored.
- Timeout: a counter runs from acceptance of start through ARM and MEAS. Reaching TIMEOUT_CYC forces DONE with timeout=1 and all four result outputs set to 0.
- Busy handling: start is ignored while busy. Inputs that change during a run do not affect it.
- Latency, synchronous input: done arrives 3 + (wait to first edge) + period_sum + CNT_W + 10 + 1 cycles after start.

Decomposition:
- Shared package sigmeas_pkg: FSM state enum {IDLE, ARM, MEAS, DIV, DONE}, DUTY_SCALE = 1000, DUTY_W = 10.
- One natural sub-module, seq_divider #(NUM_W, DEN_W). It has a start/busy/done handshake, is fixed-latency restoring, and is reusable by other measurement blocks.
- The synchroniser is an inline generate loop, not a sub-module.

Test Plan:
- Test 1: sig_in[0] driven synchronously with a 100-clk period, 40 high; k=3; rising edge. Expect period_sum=800, high_sum=320, period_avg=100, duty_pm=400, done as a single pulse with busy low in that cycle, and timeout=0.
- Test 2: ch_sel=2 with a 60-clk period, 33 high; k=0; edge_pol=1; other channels toggle randomly. Expect period_sum=60, high_sum=33, period_avg=60, duty_pm=550.
- Test 3: TIMEOUT_CYC=1000 with the selected channel held low. Expect done exactly 1000 cycles after start acceptance, timeout=1 and all results 0. The next start clears timeout and a valid run then completes.
- Test 4: avg_log2=7 with MAX_AVG_LOG2=4 and a 50-clk period, 25 high. Expect period_sum=800, period_avg=50, duty_pm=500. Extra start pulses during busy produce no additional done.
- Test 5: rst_n asserted mid-MEAS. Expect all outputs 0 immediately, asynchronously. After release, a start with a 100/40 waveform and k=3 gives Test 1's values.
- Test 6: asynchronous real-delay waveform, 2000 ns at 40% and then 1200 ns at 55%, 50 MHz clock, k=3. Expect period_sum 800±1 and 480±1, high_sum 320±2 and 264±2, duty_pm 400±3 and 550±3.

Source files
------------

// File: rtl/sigmeas_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the signal measurement blocks.
package sigmeas_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        MEAS = 3'd2,
        DIV  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int DUTY_SCALE = 1000;
    localparam int DUTY_W     = 10;

    // Limit the requested averaging exponent to what the edge counter can hold.
    function automatic logic [2:0] clamp_log2(input logic [2:0] k, input int unsigned max_k);
        if ({29'd0, k} > max_k) begin
            return max_k[2:0];
        end
        return k;
    endfunction

endpackage

// File: rtl/signal_measure_multi_div.sv
`timescale 1ns/1ps
// Fixed-latency restoring divider: one quotient bit per clock.
// The start cycle already performs the first iteration, so done pulses
// exactly NUM_W cycles after start with the quotient on quo.
// A start while busy restarts the division.
module seq_divider #(
    parameter int NUM_W = 36,
    parameter int DEN_W = 26
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    localparam int IT_W = $clog2(NUM_W + 1);

    if (NUM_W < 2) begin : g_bad_num_w
        $error("seq_divider needs NUM_W >= 2");
    end

    logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d, src_rem, src_den;
    logic [NUM_W-1:0] shift_q, shift_d, src_shift;
    logic [IT_W-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DEN_W:0]   trial, trial_sub;
    logic             fits;

    // One restoring step; shift_q holds the unconsumed numerator bits above
    // the quotient bits produced so far.
    always_comb begin
        src_rem   = start ? '0  : rem_q;
        src_shift = start ? num : shift_q;
        src_den   = start ? den : den_q;
        trial     = {src_rem, src_shift[NUM_W-1]};
        trial_sub = trial - {1'b0, src_den};
        fits      = (trial >= {1'b0, src_den});

        rem_d   = rem_q;
        shift_d = shift_q;
        den_d   = den_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (start || busy_q) begin
            rem_d   = fits ? trial_sub[DEN_W-1:0] : trial[DEN_W-1:0];
            shift_d = {src_shift[NUM_W-2:0], fits};
            den_d   = src_den;
        end

        if (start) begin
            cnt_d  = IT_W'(NUM_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - IT_W'(1);
            if (cnt_q == IT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            den_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            den_q   <= den_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = shift_q;

endmodule

// File: rtl/signal_measure_multi.sv
`timescale 1ns/1ps
// Multi-channel period / high-time measurement engine. One FSM is shared
// across N_CH synchronised inputs; averages over 2^k reference periods and
// derives a per-mille duty cycle through a sequential divider.
module signal_measure_multi
    import sigmeas_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int N_CH         = 4,
    parameter int CNT_W        = 26,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int TIMEOUT_CYC  = CLK_FREQ
)(
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
    input  logic [2:0]                              avg_log2,
    input  logic                                    edge_pol,
    input  logic [N_CH-1:0]                         sig_in,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    timeout,
    output logic [CNT_W-1:0]                        period_sum,
    output logic [CNT_W-1:0]                        high_sum,
    output logic [CNT_W-1:0]                        period_avg,
    output logic [DUTY_W-1:0]                       duty_pm
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CH_N  = 1 << CH_W;
    localparam int EC_W  = MAX_AVG_LOG2 + 1;
    localparam int NUM_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    if (TIMEOUT_CYC < 2 || 64'(TIMEOUT_CYC) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in [2, 2^CNT_W)");
    end
    if (MAX_AVG_LOG2 > 7 || N_CH < 1) begin : g_bad_cfg
        $error("MAX_AVG_LOG2 must be <= 7 and N_CH >= 1");
    end

    genvar gi;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [2:0]        k_q, k_d;
    logic              pol_q, pol_d;
    logic [CNT_W-1:0]  per_acc_q, per_acc_d, high_acc_q, high_acc_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [EC_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  period_sum_q, period_sum_d, high_sum_q, high_sum_d;
    logic [CNT_W-1:0]  period_avg_q, period_avg_d;
    logic [DUTY_W-1:0] duty_q, duty_d;

    logic [N_CH-1:0]   lvl, edg;
    logic [CH_N-1:0]   lvl_ext, edg_ext;
    logic              sel_lvl, sel_edge, last_edge, tmo_hit, abort;
    logic [CNT_W-1:0]  lvl_cnt;
    logic [EC_W-1:0]   edge_target;

    logic              div_start, div_busy, div_done;
    logic [NUM_W-1:0]  div_num, div_quo;

    // Per-channel 2-FF synchroniser and edge-detect delay stage.
    for (gi = 0; gi < N_CH; gi++) begin : g_sync
        logic s1_q, s2_q, dly_q;

        // Shift the raw pin through the synchroniser and the delay register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                dly_q <= 1'b0;
            end else begin
                s1_q  <= sig_in[gi];
                s2_q  <= s1_q;
                dly_q <= s2_q;
            end
        end

        assign lvl[gi] = s2_q;
        assign edg[gi] = pol_q ? (dly_q & ~s2_q) : (s2_q & ~dly_q);
    end

    // Pad to a power of two so any ch_sel code indexes safely (unused codes read 0).
    for (gi = 0; gi < CH_N; gi++) begin : g_pad
        if (gi < N_CH) begin : g_real
            assign lvl_ext[gi] = lvl[gi];
            assign edg_ext[gi] = edg[gi];
        end else begin : g_none
            assign lvl_ext[gi] = 1'b0;
            assign edg_ext[gi] = 1'b0;
        end
    end

    assign sel_lvl     = lvl_ext[ch_q];
    assign sel_edge    = edg_ext[ch_q];
    assign lvl_cnt     = {{(CNT_W-1){1'b0}}, sel_lvl};
    assign edge_target = EC_W'(1) << k_q;
    assign last_edge   = (edge_cnt_q + EC_W'(1)) == edge_target;
    assign tmo_hit     = (tmo_cnt_q >= TMO_LAST);
    assign div_num     = NUM_W'(high_acc_q) * NUM_W'(DUTY_SCALE);

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .num   (div_num),
        .den   (per_acc_q),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    // Next-state and datapath updates for the measurement FSM.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        k_d          = k_q;
        pol_d        = pol_q;
        per_acc_d    = per_acc_q;
        high_acc_d   = high_acc_q;
        edge_cnt_d   = edge_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = timeout_q;
        period_sum_d = period_sum_q;
        high_sum_d   = high_sum_q;
        period_avg_d = period_avg_q;
        duty_d       = duty_q;
        div_start    = 1'b0;
        abort        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d       = ch_sel;
                    k_d        = clamp_log2(avg_log2, MAX_AVG_LOG2);
                    pol_d      = edge_pol;
                    timeout_d  = 1'b0;
                    per_acc_d  = '0;
                    high_acc_d = '0;
                    edge_cnt_d = '0;
                    tmo_cnt_d  = '0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (tmo_hit) begin
                    abort = 1'b1;
                end else if (sel_edge) begin
                    // The arming edge cycle is the first cycle of the window.
                    per_acc_d  = CNT_W'(1);
                    high_acc_d = lvl_cnt;
                    state_d    = MEAS;
                end
            end
            MEAS: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                if (sel_edge && last_edge) begin
                    // Closing edge is excluded so the window is exactly 2^k periods.
                    div_start = 1'b1;
                    state_d   = DIV;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end else begin
                    per_acc_d  = per_acc_q + CNT_W'(1);
                    high_acc_d = high_acc_q + lvl_cnt;
                    if (sel_edge) begin
                        edge_cnt_d = edge_cnt_q + EC_W'(1);
                    end
                end
            end
            DIV: begin
                if (div_done && !div_busy) begin
                    period_sum_d = per_acc_q;
                    high_sum_d   = high_acc_q;
                    period_avg_d = per_acc_q >> k_q;
                    duty_d       = (div_quo > NUM_W'(DUTY_SCALE)) ? DUTY_W'(DUTY_SCALE)
                                                                  : div_quo[DUTY_W-1:0];
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d      = DONE;
            timeout_d    = 1'b1;
            period_sum_d = '0;
            high_sum_d   = '0;
            period_avg_d = '0;
            duty_d       = '0;
        end
    end

    // FSM, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            k_q          <= '0;
            pol_q        <= 1'b0;
            per_acc_q    <= '0;
            high_acc_q   <= '0;
            edge_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            period_sum_q <= '0;
            high_sum_q   <= '0;
            period_avg_q <= '0;
            duty_q       <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            k_q          <= k_d;
            pol_q        <= pol_d;
            per_acc_q    <= per_acc_d;
            high_acc_q   <= high_acc_d;
            edge_cnt_q   <= edge_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            period_sum_q <= period_sum_d;
            high_sum_q   <= high_sum_d;
            period_avg_q <= period_avg_d;
            duty_q       <= duty_d;
        end
    end

    assign busy       = (state_q == ARM) || (state_q == MEAS) || (state_q == DIV);
    assign done       = (state_q == DONE);
    assign timeout    = timeout_q;
    assign period_sum = period_sum_q;
    assign high_sum   = high_sum_q;
    assign period_avg = period_avg_q;
    assign duty_pm    = duty_q;

endmodule

// File: tb/tb_signal_measure_multi.sv
`timescale 1ns/1ps
// Directed bench for signal_measure_multi: table of waveform/expectation
// records plus hand-written timeout and mid-run reset sequences.
module tb_signal_measure_multi;

    localparam int N_CH  = 4;
    localparam int CNT_W = 26;
    localparam int TMO   = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       ch_sel = '0;
    logic [2:0]       avg_log2 = '0;
    logic             edge_pol = 1'b0;
    logic [N_CH-1:0]  sig_in;
    logic             busy, done, timeout;
    logic [CNT_W-1:0] period_sum, high_sum, period_avg;
    logic [9:0]       duty_pm;

    always #10 clk = ~clk;   // 50 MHz

    signal_measure_multi #(
        .CLK_FREQ     (50_000_000),
        .N_CH         (N_CH),
        .CNT_W        (CNT_W),
        .MAX_AVG_LOG2 (4),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ch_sel     (ch_sel),
        .avg_log2   (avg_log2),
        .edge_pol   (edge_pol),
        .sig_in     (sig_in),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .period_sum (period_sum),
        .high_sum   (high_sum),
        .period_avg (period_avg),
        .duty_pm    (duty_pm)
    );

    // Waveform generator: mode 0 = hold low, 1 = clock-synchronous (clk units),
    // 2 = free-running real delays (ns units), offset from the clock.
    int   gen_mode = 0;
    int   gen_per  = 100;
    int   gen_high = 40;
    int   gen_ch   = 0;
    logic gen_bit  = 1'b0;
    logic [N_CH-1:0] noise = '0;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sig_in[i] = (i == gen_ch) ? gen_bit : noise[i];
        end
    end

    always @(negedge clk) noise <= N_CH'($urandom);

    initial begin
        int m, p, h, prev;
        prev = 0;
        forever begin
            m = gen_mode;
            p = gen_per;
            h = gen_high;
            if (m == 1) begin
                gen_bit = 1'b1;
                repeat (h) @(posedge clk);
                #1;
                gen_bit = 1'b0;
                repeat (p - h) @(posedge clk);
                #1;
            end else if (m == 2) begin
                if (prev != 2) #7;
                gen_bit = 1'b1;
                #(h);
                gen_bit = 1'b0;
                #(p - h);
            end else begin
                gen_bit = 1'b0;
                @(posedge clk);
                #1;
            end
            prev = m;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        longint d;
        n_cmp++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // Issue one start, scramble the request inputs while busy, wait for done.
    // lat = clock edges from the accepting edge to the edge that raises done.
    task automatic run_meas(input int ch, input int k, input bit pol, input bit extra,
                            output int lat, output bit got);
        int n;
        @(posedge clk); #1;
        ch_sel   = 2'(ch);
        avg_log2 = 3'(k);
        edge_pol = pol;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        ch_sel   = 2'(ch + 1);
        avg_log2 = ~3'(k);
        edge_pol = ~pol;
        chk("busy_after_start", busy, 1, 0);
        chk("timeout_clr_at_start", timeout, 0, 0);
        got = 1'b0;
        lat = 0;
        n   = 0;
        while (!got && n < 3000) begin
            @(posedge clk);
            n++;
            #1;
            start = extra && (n == 20 || n == 300 || n == 600);
            if (done) begin
                got = 1'b1;
                lat = n;
                chk("busy_low_in_done", busy, 0, 0);
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1, 0);
        @(posedge clk); #1;
        chk("done_single_pulse", done, 0, 0);
    endtask

    typedef struct {
        int     ch;
        int     k;
        bit     pol;
        int     mode;
        int     per;
        int     high;
        bit     extra;
        longint e_per;
        longint e_high;
        longint e_avg;
        longint e_duty;
        int     tp;
        int     th;
        int     ta;
        int     td;
    } vec_t;

    vec_t tbl[5];

    task automatic check_results(input longint ep, input longint eh, input longint ea,
                                 input longint ed, input int tp, input int th,
                                 input int ta, input int td);
        chk("period_sum", period_sum, ep, tp);
        chk("high_sum",   high_sum,   eh, th);
        chk("period_avg", period_avg, ea, ta);
        chk("duty_pm",    duty_pm,    ed, td);
        chk("timeout",    timeout,    0,  0);
    endtask

    initial begin
        int  lat;
        bit  got;
        int  extra_dones;

        //        ch k  pol mode per   high extra  per  high avg duty  tolerances
        tbl[0] = '{0, 3, 1'b0, 1, 100,  40,  1'b0, 800, 320, 100, 400, 0, 0, 0, 0};
        tbl[1] = '{2, 0, 1'b1, 1, 60,   33,  1'b0, 60,  33,  60,  550, 0, 0, 0, 0};
        tbl[2] = '{1, 7, 1'b0, 1, 50,   25,  1'b1, 800, 400, 50,  500, 0, 0, 0, 0};
        tbl[3] = '{3, 3, 1'b0, 2, 2000, 800, 1'b0, 800, 320, 100, 400, 1, 2, 1, 3};
        tbl[4] = '{3, 3, 1'b0, 2, 1200, 660, 1'b0, 480, 264, 60,  550, 1, 2, 1, 3};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",       busy,       0, 0);
        chk("rst_done",       done,       0, 0);
        chk("rst_timeout",    timeout,    0, 0);
        chk("rst_period_sum", period_sum, 0, 0);
        chk("rst_high_sum",   high_sum,   0, 0);
        chk("rst_period_avg", period_avg, 0, 0);
        chk("rst_duty_pm",    duty_pm,    0, 0);
        rst_n = 1'b1;

        // Table-driven measurements.
        for (int v = 0; v < 5; v++) begin
            gen_ch   = tbl[v].ch;
            gen_per  = tbl[v].per;
            gen_high = tbl[v].high;
            gen_mode = tbl[v].mode;
            repeat (250) @(posedge clk);
            run_meas(tbl[v].ch, tbl[v].k, tbl[v].pol, tbl[v].extra, lat, got);
            $display("vec %0d: ch=%0d k=%0d period_sum=%0d high_sum=%0d period_avg=%0d duty_pm=%0d timeout=%0d lat=%0d",
                     v, tbl[v].ch, tbl[v].k, period_sum, high_sum, period_avg, duty_pm, timeout, lat);
            check_results(tbl[v].e_per, tbl[v].e_high, tbl[v].e_avg, tbl[v].e_duty,
                          tbl[v].tp, tbl[v].th, tbl[v].ta, tbl[v].td);
            if (tbl[v].extra) begin
                extra_dones = 0;
                repeat (200) begin
                    @(posedge clk); #1;
                    if (done) extra_dones++;
                end
                chk("no_extra_done", extra_dones, 0, 0);
            end
        end

        // Timeout on a channel held low, then recovery.
        gen_ch   = 1;
        gen_mode = 0;
        repeat (20) @(posedge clk);
        run_meas(1, 3, 1'b0, 1'b0, lat, got);
        $display("timeout run: timeout=%0d period_sum=%0d high_sum=%0d period_avg=%0d duty_pm=%0d lat=%0d",
                 timeout, period_sum, high_sum, period_avg, duty_pm, lat);
        chk("tmo_latency",    lat,        TMO, 0);
        chk("tmo_flag",       timeout,    1,   0);
        chk("tmo_period_sum", period_sum, 0,   0);
        chk("tmo_high_sum",   high_sum,   0,   0);
        chk("tmo_period_avg", period_avg, 0,   0);
        chk("tmo_duty_pm",    duty_pm,    0,   0);
        gen_per  = 100;
        gen_high = 40;
        gen_mode = 1;
        repeat (250) @(posedge clk);
        run_meas(1, 0, 1'b0, 1'b0, lat, got);
        $display("recovery run: period_sum=%0d high_sum=%0d period_avg=%0d duty_pm=%0d timeout=%0d lat=%0d",
                 period_sum, high_sum, period_avg, duty_pm, timeout, lat);
        check_results(100, 40, 100, 400, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a measurement.
        gen_ch = 0;
        repeat (250) @(posedge clk);
        @(posedge clk); #1;
        ch_sel   = 2'd0;
        avg_log2 = 3'd3;
        edge_pol = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        $display("mid-run reset: busy=%0d done=%0d timeout=%0d period_sum=%0d high_sum=%0d period_avg=%0d duty_pm=%0d",
                 busy, done, timeout, period_sum, high_sum, period_avg, duty_pm);
        chk("mrst_busy",       busy,       0, 0);
        chk("mrst_done",       done,       0, 0);
        chk("mrst_timeout",    timeout,    0, 0);
        chk("mrst_period_sum", period_sum, 0, 0);
        chk("mrst_high_sum",   high_sum,   0, 0);
        chk("mrst_period_avg", period_avg, 0, 0);
        chk("mrst_duty_pm",    duty_pm,    0, 0);
        repeat (3) @(posedge clk);
        #5;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        run_meas(0, 3, 1'b0, 1'b0, lat, got);
        $display("post-reset run: period_sum=%0d high_sum=%0d period_avg=%0d duty_pm=%0d timeout=%0d lat=%0d",
                 period_sum, high_sum, period_avg, duty_pm, timeout, lat);
        check_results(800, 320, 100, 400, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
